// File: rtl/video_in_frame_sequencer_if.sv
// Bus bundle between the frame sequencer, the video-in DMA control slave and the frame consumer.
// ctrl_*: Avalon-MM, one-cycle read/write strobes, ctrl_readdata valid the cycle after ctrl_read.
// frame_*: a frame transfers on any edge where frame_valid && frame_ready; while valid is high and
// ready is low, frame_valid and frame_addr hold unless a newer frame replaces the pending one.
interface video_in_frame_sequencer_if;
  logic [1:0]  ctrl_address;
  logic        ctrl_read;
  logic        ctrl_write;
  logic [31:0] ctrl_writedata;
  logic [3:0]  ctrl_byteenable;
  logic [31:0] ctrl_readdata;
  logic        frame_valid;
  logic [31:0] frame_addr;
  logic        frame_ready;

  modport master (
    output ctrl_address, ctrl_read, ctrl_write, ctrl_writedata, ctrl_byteenable,
    input  ctrl_readdata,
    output frame_valid, frame_addr,
    input  frame_ready
  );

  modport slave (
    input  ctrl_address, ctrl_read, ctrl_write, ctrl_writedata, ctrl_byteenable,
    output ctrl_readdata,
    input  frame_valid, frame_addr,
    output frame_ready
  );
endinterface

// File: rtl/video_in_frame_sequencer.sv
// N-buffer capture sequencer: programs the DMA back buffer, requests a swap, polls for completion
// and publishes each completed frame address to a downstream consumer.
module video_in_frame_sequencer #(
  parameter int          NUM_BUF      = 3,
  parameter logic [31:0] BUF_BASE     = 32'h0800_0000,
  parameter logic [31:0] BUF_STRIDE   = 32'h0002_5800,
  parameter int          POLL_GAP     = 16,
  parameter int          POLL_TIMEOUT = 2_000_000
) (
  input  logic                         sys_clk_clk,
  input  logic                         sys_reset_reset_n,
  input  logic                         enable,
  video_in_frame_sequencer_if.master   bus,
  output logic [15:0]                  frames_dropped,
  output logic                         timeout_err,
  output logic                         busy,
  output logic [2:0]                   state_dbg
);

  localparam int IDX_W = $clog2(NUM_BUF);
  localparam int TO_W  = $clog2(POLL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_BACK = 3'd1,
    WR_SWAP = 3'd2,
    GAP     = 3'd3,
    RD      = 3'd4,
    SAMPLE  = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cur, nxt_idx;
  logic             primed;
  logic [7:0]       gap_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             frame_valid_q;
  logic [31:0]      frame_addr_q;

  logic gap_done, timed_out, pending, publish, accept;

  function automatic logic [31:0] addr_of(input logic [IDX_W-1:0] idx);
    return BUF_BASE + BUF_STRIDE * 32'(idx);
  endfunction

  assign nxt_idx   = (cur == IDX_W'(NUM_BUF - 1)) ? '0 : cur + IDX_W'(1);
  assign gap_done  = (gap_cnt == 8'(POLL_GAP - 1));
  assign timed_out = (to_cnt >= TO_W'(POLL_TIMEOUT));
  assign pending   = bus.ctrl_readdata[0];
  assign publish   = (state == DONE) && primed;
  assign accept    = frame_valid_q && bus.frame_ready;

  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) state <= IDLE;
    else                    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && !timeout_err) state_nxt = WR_BACK;
      WR_BACK: state_nxt = WR_SWAP;
      WR_SWAP: state_nxt = GAP;
      GAP:     if (gap_done) state_nxt = RD;
      RD:      state_nxt = SAMPLE;
      SAMPLE: begin
        if (!pending)       state_nxt = DONE;
        else if (timed_out) state_nxt = IDLE;
        else if (!enable)   state_nxt = IDLE;
        else                state_nxt = GAP;
      end
      DONE:    state_nxt = enable ? WR_BACK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode straight from the state register so a reset drops them in the same cycle.
  always_comb begin
    bus.ctrl_address   = 2'd0;
    bus.ctrl_read      = 1'b0;
    bus.ctrl_write     = 1'b0;
    bus.ctrl_writedata = 32'd0;
    case (state)
      WR_BACK: begin
        bus.ctrl_write     = 1'b1;
        bus.ctrl_address   = 2'd1;
        bus.ctrl_writedata = addr_of(nxt_idx);
      end
      WR_SWAP: begin
        bus.ctrl_write   = 1'b1;
        bus.ctrl_address = 2'd0;
      end
      RD: begin
        bus.ctrl_read    = 1'b1;
        bus.ctrl_address = 2'd3;
      end
      default: ;
    endcase
  end

  assign bus.ctrl_byteenable = 4'hF;
  assign bus.frame_valid     = frame_valid_q;
  assign bus.frame_addr      = frame_addr_q;
  assign busy                = (state != IDLE);
  assign state_dbg           = state;

  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) begin
      cur     <= '0;
      primed  <= 1'b0;
      gap_cnt <= 8'd0;
      to_cnt  <= '0;
    end else begin
      gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
      if (state == WR_SWAP)
        to_cnt <= '0;
      else if ((state == GAP || state == RD || state == SAMPLE) && !timed_out)
        to_cnt <= to_cnt + TO_W'(1);
      // Any pass through IDLE invalidates the buffer the DMA was filling.
      if (state == IDLE) primed <= 1'b0;
      if (state == DONE) begin
        primed <= enable;
        cur    <= nxt_idx;
      end
    end
  end

  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) begin
      timeout_err <= 1'b0;
    end else if (state == SAMPLE && pending && timed_out) begin
      timeout_err <= 1'b1;
    end else if (!enable) begin
      timeout_err <= 1'b0;
    end
  end

  // An unaccepted pending frame is replaced by the newer one and counted as dropped.
  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) begin
      frame_valid_q  <= 1'b0;
      frame_addr_q   <= 32'd0;
      frames_dropped <= 16'd0;
    end else if (publish) begin
      frame_valid_q <= 1'b1;
      frame_addr_q  <= addr_of(cur);
      if (frame_valid_q && !bus.frame_ready && frames_dropped != 16'hFFFF)
        frames_dropped <= frames_dropped + 16'd1;
    end else if (accept) begin
      frame_valid_q <= 1'b0;
    end
  end

endmodule
